// File: rtl/syn_branch_target_predictor_pkg.sv
// Shared constants and counter-init helpers for the branch target predictor.
// Counter init values are derived from the counter width.
package syn_branch_target_predictor_pkg;

  localparam int STAT_W          = 16;
  localparam int DEF_IM_ADDR_BIT = 10;
  localparam int DEF_INDEX_BIT   = 6;
  localparam int DEF_CTR_BITS    = 2;

  function automatic int tag_bits(input int im_addr_bit, input int index_bit);
    return im_addr_bit - index_bit;
  endfunction

  function automatic int entry_count(input int index_bit);
    return 1 << index_bit;
  endfunction

  function automatic logic [3:0] ctr_weak_taken(input int ctr_bits);
    return 4'(1 << (ctr_bits - 1));
  endfunction

  function automatic logic [3:0] ctr_weak_not_taken(input int ctr_bits);
    return 4'((1 << (ctr_bits - 1)) - 1);
  endfunction

endpackage

// File: rtl/syn_branch_target_predictor_cmb_sat_counter_next.sv
// Saturating up/down counter next-state logic used to train direction counters.
module cmb_sat_counter_next #(
  parameter int CTR_BITS = 2
) (
  input  logic [CTR_BITS-1:0] ctr,
  input  logic                taken,
  output logic [CTR_BITS-1:0] ctr_next
);

  // Step toward the observed outcome, holding at either end of the range.
  always_comb begin
    ctr_next = ctr;
    if (taken) begin
      if (ctr == {CTR_BITS{1'b1}}) begin
        ctr_next = ctr;
      end else begin
        ctr_next = ctr + CTR_BITS'(1);
      end
    end else begin
      if (ctr == {CTR_BITS{1'b0}}) begin
        ctr_next = ctr;
      end else begin
        ctr_next = ctr - CTR_BITS'(1);
      end
    end
  end

endmodule

// File: rtl/syn_branch_target_predictor.sv
// Direct-mapped branch target buffer with saturating direction counters.
// Optional statistics counters are built when BHT_STATS_EN is defined.
module syn_branch_target_predictor
  import syn_branch_target_predictor_pkg::*;
#(
  parameter int IM_ADDR_BIT = DEF_IM_ADDR_BIT,
  parameter int INDEX_BIT   = DEF_INDEX_BIT,
  parameter int CTR_BITS    = DEF_CTR_BITS
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   en,
  input  logic [IM_ADDR_BIT-1:0] pc,
  output logic [IM_ADDR_BIT-1:0] pc_guessed,
  output logic                   pred_taken,
  input  logic                   upd_en,
  input  logic [IM_ADDR_BIT-1:0] upd_pc,
  input  logic                   upd_taken,
  input  logic [IM_ADDR_BIT-1:0] upd_target,
  input  logic                   upd_mispredict,
  input  logic                   flush,
  output logic [STAT_W-1:0]      stat_updates,
  output logic [STAT_W-1:0]      stat_mispredicts
);

  localparam int TAG_BIT = tag_bits(IM_ADDR_BIT, INDEX_BIT);
  localparam int ENTRIES = entry_count(INDEX_BIT);
  localparam logic [CTR_BITS-1:0] CTR_WT  = CTR_BITS'(ctr_weak_taken(CTR_BITS));
  localparam logic [CTR_BITS-1:0] CTR_WNT = CTR_BITS'(ctr_weak_not_taken(CTR_BITS));

  logic [ENTRIES-1:0]     r_valid;
  logic [TAG_BIT-1:0]     r_tag    [ENTRIES];
  logic [IM_ADDR_BIT-1:0] r_target [ENTRIES];
  logic [CTR_BITS-1:0]    r_ctr    [ENTRIES];

  logic [INDEX_BIT-1:0] w_idx;
  logic [TAG_BIT-1:0]   w_tag;
  logic                 w_hit;
  logic [INDEX_BIT-1:0] w_upd_idx;
  logic [TAG_BIT-1:0]   w_upd_tag;
  logic                 w_upd_hit;
  logic [CTR_BITS-1:0]  w_ctr_next;
  logic                 w_upd_fire;

  assign w_idx      = pc[INDEX_BIT-1:0];
  assign w_tag      = pc[IM_ADDR_BIT-1:INDEX_BIT];
  assign w_upd_idx  = upd_pc[INDEX_BIT-1:0];
  assign w_upd_tag  = upd_pc[IM_ADDR_BIT-1:INDEX_BIT];
  assign w_hit      = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
  assign w_upd_hit  = r_valid[w_upd_idx] && (r_tag[w_upd_idx] == w_upd_tag);
  assign w_upd_fire = en && upd_en && !flush;

  // Lookup reads current table contents; updates land only at the next edge.
  assign pred_taken = w_hit && r_ctr[w_idx][CTR_BITS-1];
  assign pc_guessed = pred_taken ? r_target[w_idx] : (pc + IM_ADDR_BIT'(1));

  cmb_sat_counter_next #(
    .CTR_BITS (CTR_BITS)
  ) u_ctr_next (
    .ctr      (r_ctr[w_upd_idx]),
    .taken    (upd_taken),
    .ctr_next (w_ctr_next)
  );

  // Valid bits and direction counters: flush beats update, misses allocate only when taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= {ENTRIES{1'b0}};
      for (int i = 0; i < ENTRIES; i++) begin
        r_ctr[i] <= CTR_WNT;
      end
    end else if (en) begin
      if (flush) begin
        r_valid <= {ENTRIES{1'b0}};
      end else if (upd_en) begin
        if (w_upd_hit) begin
          r_ctr[w_upd_idx] <= w_ctr_next;
        end else if (upd_taken) begin
          r_valid[w_upd_idx] <= 1'b1;
          r_ctr[w_upd_idx]   <= CTR_WT;
        end
      end
    end
  end

  // Tag and target payload; left unreset since valid gates every use of it.
  always_ff @(posedge clk) begin
    if (rst_n && w_upd_fire && upd_taken) begin
      r_tag[w_upd_idx]    <= w_upd_tag;
      r_target[w_upd_idx] <= upd_target;
    end
  end

`ifdef BHT_STATS_EN
  logic [STAT_W-1:0] r_stat_upd;
  logic [STAT_W-1:0] r_stat_mis;

  // Saturating resolved/mispredict counters; flush does not touch them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stat_upd <= {STAT_W{1'b0}};
      r_stat_mis <= {STAT_W{1'b0}};
    end else if (en && upd_en) begin
      if (r_stat_upd != {STAT_W{1'b1}}) begin
        r_stat_upd <= r_stat_upd + STAT_W'(1);
      end
      if (upd_mispredict && (r_stat_mis != {STAT_W{1'b1}})) begin
        r_stat_mis <= r_stat_mis + STAT_W'(1);
      end
    end
  end

  assign stat_updates     = r_stat_upd;
  assign stat_mispredicts = r_stat_mis;
`else
  logic w_unused_mispredict;

  assign w_unused_mispredict = upd_mispredict;
  assign stat_updates        = {STAT_W{1'b0}};
  assign stat_mispredicts    = {STAT_W{1'b0}};
`endif

endmodule

// File: tb/tb_syn_branch_target_predictor.sv
// Scoreboard bench: stimulus pushes reference-model expectations, a monitor checks them.
module tb_syn_branch_target_predictor;

  localparam int IA = 10;
  localparam int IX = 6;
  localparam int CB = 2;
  localparam int NE = 1 << IX;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          en;
  logic [IA-1:0] pc;
  logic [IA-1:0] pc_guessed;
  logic          pred_taken;
  logic          upd_en;
  logic [IA-1:0] upd_pc;
  logic          upd_taken;
  logic [IA-1:0] upd_target;
  logic          upd_mispredict;
  logic          flush;
  logic [15:0]   stat_updates;
  logic [15:0]   stat_mispredicts;

  syn_branch_target_predictor #(
    .IM_ADDR_BIT (IA),
    .INDEX_BIT   (IX),
    .CTR_BITS    (CB)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .en               (en),
    .pc               (pc),
    .pc_guessed       (pc_guessed),
    .pred_taken       (pred_taken),
    .upd_en           (upd_en),
    .upd_pc           (upd_pc),
    .upd_taken        (upd_taken),
    .upd_target       (upd_target),
    .upd_mispredict   (upd_mispredict),
    .flush            (flush),
    .stat_updates     (stat_updates),
    .stat_mispredicts (stat_mispredicts)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [IA-1:0] guess;
    logic          taken;
    logic [15:0]   su;
    logic [15:0]   sm;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: one record per index, counter kept as a plain integer
  bit m_valid [NE];
  int m_tag   [NE];
  int m_tgt   [NE];
  int m_ctr   [NE];
  int m_su;
  int m_sm;

  function automatic void model_reset();
    for (int i = 0; i < NE; i++) begin
      m_valid[i] = 1'b0;
      m_ctr[i]   = (1 << (CB - 1)) - 1;
    end
    m_su = 0;
    m_sm = 0;
  endfunction

  function automatic void model_update(input bit e, input bit ue, input int up, input bit ut,
                                       input int utg, input bit um, input bit fl);
    int  idx;
    int  tg;
    bit  hit;
    idx = up % NE;
    tg  = up / NE;
    hit = m_valid[idx] && (m_tag[idx] == tg);
    if (e && ue) begin
      if (m_su < 65535) m_su++;
      if (um && m_sm < 65535) m_sm++;
    end
    if (e && fl) begin
      for (int i = 0; i < NE; i++) m_valid[i] = 1'b0;
    end else if (e && ue) begin
      if (ut && hit) begin
        m_ctr[idx] = (m_ctr[idx] < (1 << CB) - 1) ? m_ctr[idx] + 1 : m_ctr[idx];
        m_tgt[idx] = utg;
      end else if (ut) begin
        m_valid[idx] = 1'b1;
        m_tag[idx]   = tg;
        m_tgt[idx]   = utg;
        m_ctr[idx]   = 1 << (CB - 1);
      end else if (hit) begin
        m_ctr[idx] = (m_ctr[idx] > 0) ? m_ctr[idx] - 1 : 0;
      end
    end
  endfunction

  function automatic exp_t model_lookup(input int p);
    exp_t e;
    int   idx;
    bit   pt;
    idx = p % NE;
    pt  = m_valid[idx] && (m_tag[idx] == p / NE) && (m_ctr[idx] >= (1 << (CB - 1)));
    e.taken = pt;
    e.guess = pt ? IA'(m_tgt[idx]) : IA'((p + 1) % (1 << IA));
`ifdef BHT_STATS_EN
    e.su = 16'(m_su);
    e.sm = 16'(m_sm);
`else
    e.su = 16'd0;
    e.sm = 16'd0;
`endif
    return e;
  endfunction

  // One cycle of stimulus, driven just after the rising edge.
  task automatic step(input bit r, input bit e, input int p, input bit ue, input int up,
                      input bit ut, input int utg, input bit um, input bit fl);
    rst_n          = r;
    en             = e;
    pc             = IA'(p);
    upd_en         = ue;
    upd_pc         = IA'(up);
    upd_taken      = ut;
    upd_target     = IA'(utg);
    upd_mispredict = um;
    flush          = fl;
    if (!r) model_reset();
    q.push_back(model_lookup(p));
    if (r) model_update(e, ue, up, ut, utg, um, fl);
    @(posedge clk);
    #1;
  endtask

  task automatic look(input int p);
    step(1'b1, 1'b1, p, 1'b0, 0, 1'b0, 0, 1'b0, 1'b0);
  endtask

  task automatic train(input int up, input bit ut, input int utg, input bit um);
    step(1'b1, 1'b1, up, 1'b1, up, ut, utg, um, 1'b0);
  endtask

  // Monitor: outputs are stable mid-cycle, compare on the falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        checks += 4;
        if (pc_guessed !== e.guess) begin
          errors++;
          $display("FAIL pc_guessed t=%0t pc=%h got=%h want=%h", $time, pc, pc_guessed, e.guess);
        end
        if (pred_taken !== e.taken) begin
          errors++;
          $display("FAIL pred_taken t=%0t pc=%h got=%b want=%b", $time, pc, pred_taken, e.taken);
        end
        if (stat_updates !== e.su) begin
          errors++;
          $display("FAIL stat_updates t=%0t got=%h want=%h", $time, stat_updates, e.su);
        end
        if (stat_mispredicts !== e.sm) begin
          errors++;
          $display("FAIL stat_mispredicts t=%0t got=%h want=%h", $time, stat_mispredicts, e.sm);
        end
      end
    end
  end

  initial begin
    int p;
    int up;
    rst_n = 1'b0; en = 1'b0; pc = '0; upd_en = 1'b0; upd_pc = '0;
    upd_taken = 1'b0; upd_target = '0; upd_mispredict = 1'b0; flush = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    // Reset state, including the address wrap at the top of the range
    step(1'b0, 1'b1, 'h045, 1'b0, 0, 1'b0, 0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 'h3FF, 1'b0, 0, 1'b0, 0, 1'b0, 1'b0);
    look('h045);
    look('h3FF);
    // Allocation, hit, same-index different-tag miss, same-cycle lookup sees old contents
    train('h045, 1'b1, 'h100, 1'b1);
    look('h045);
    look('h005);
    // Saturation up, then training back down through the threshold and to zero
    train('h045, 1'b1, 'h100, 1'b0);
    train('h045, 1'b1, 'h100, 1'b0);
    train('h045, 1'b1, 'h100, 1'b0);
    train('h045, 1'b0, 'h000, 1'b1);
    look('h045);
    train('h045, 1'b0, 'h000, 1'b1);
    look('h045);
    train('h045, 1'b0, 'h000, 1'b0);
    train('h045, 1'b0, 'h000, 1'b0);
    train('h045, 1'b1, 'h222, 1'b1);
    look('h045);
    // Not-taken miss does not allocate
    train('h020, 1'b0, 'h155, 1'b0);
    look('h020);
    // Flush beats a simultaneous update; enable low freezes the table
    train('h045, 1'b1, 'h100, 1'b0);
    train('h045, 1'b1, 'h100, 1'b0);
    step(1'b1, 1'b1, 'h045, 1'b1, 'h045, 1'b1, 'h100, 1'b0, 1'b1);
    look('h045);
    step(1'b1, 1'b0, 'h045, 1'b1, 'h045, 1'b1, 'h100, 1'b1, 1'b0);
    look('h045);
    // Evict a different-tag occupant
    train('h0C5, 1'b1, 'h300, 1'b0);
    train('h045, 1'b1, 'h101, 1'b1);
    look('h0C5);
    look('h045);
    // Reset arriving with an update in flight discards it
    step(1'b0, 1'b1, 'h045, 1'b1, 'h045, 1'b1, 'h111, 1'b1, 1'b0);
    look('h045);
    // Randomized traffic over a few indices and tags to force hits and conflicts
    for (int i = 0; i < 3000; i++) begin
      p  = $urandom_range(3, 0) * NE + $urandom_range(7, 0);
      up = $urandom_range(3, 0) * NE + $urandom_range(7, 0);
      step(1'b1, ($urandom_range(9, 0) != 0), p, $urandom_range(1, 0), up,
           $urandom_range(1, 0), $urandom_range((1 << IA) - 1, 0),
           $urandom_range(1, 0), ($urandom_range(39, 0) == 0));
    end
`ifdef BHT_STATS_EN
    // Push both statistics counters past their ceiling
    for (int i = 0; i < 65540; i++) begin
      step(1'b1, 1'b1, $urandom_range((1 << IA) - 1, 0), 1'b1, $urandom_range((1 << IA) - 1, 0),
           $urandom_range(1, 0), $urandom_range((1 << IA) - 1, 0), 1'b1, 1'b0);
    end
    look('h045);
`endif
    for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
    #1;
    checks++;
    if (q.size() > 0) begin
      errors++;
      $display("FAIL drain pending=%0d want=0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/syn_branch_target_predictor.md
Name: syn_branch_target_predictor

Overview:
- Parametrised branch target buffer with saturating-counter direction prediction for the 5-stage Laji pipeline.
- Replaces the fixed "pc_guessed = pc_4" guess at IF (ps0) with a table lookup.
- Trained from EX/DM (ps3) once CmbWTG resolves the real next PC.
- Direct-mapped: one entry per index holds valid, tag, target and counter.

Parameters:
- IM_ADDR_BIT, 10, width of the word PC (byte PC >> 2).
- INDEX_BIT, 6, log2 of entry count (64 entries); must be < IM_ADDR_BIT.
- CTR_BITS, 2, saturating counter width, 1..4.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- en  in  1  global enable; when low, no state changes.
- pc  in  IM_ADDR_BIT  ps0 fetch word address.
- pc_guessed  out  IM_ADDR_BIT  predicted next word address.
- pred_taken  out  1  prediction is a taken redirect.
- upd_en  in  1  ps3 resolved branch/jump this cycle.
- upd_pc  in  IM_ADDR_BIT  word address of the resolved instruction.
- upd_taken  in  1  actual outcome; 1 for all jumps.
- upd_target  in  IM_ADDR_BIT  actual taken target.
- upd_mispredict  in  1  ps3 prediction was wrong (!pred_succ).
- flush  in  1  invalidate the whole table.
- stat_updates  out  16  resolved-branch count.
- stat_mispredicts  out  16  misprediction count.

Behaviour:
- Addressing:
  - index = pc[INDEX_BIT-1:0].
  - tag = pc[IM_ADDR_BIT-1:INDEX_BIT].
  - The same split applies to upd_pc.
- Lookup (combinational, zero latency, same cycle as pc):
  - hit = valid[index] && tag match.
  - pred_taken = hit && counter MSB.
  - pc_guessed = pred_taken ? target : pc+1, modulo 2^IM_ADDR_BIT. PC 0x3FF wraps to 0x000.
- Reset (async, rst_n low):
  - All valid bits clear; counters set to weakly-not-taken, 2^(CTR_BITS-1)-1.
  - Stats clear to 0.
  - Outputs immediately: pred_taken=0, pc_guessed=pc+1.
  - Tags and targets need no reset.
  - A reset mid-update discards that update.
- Update (rising edge, en && upd_en && !flush):
  - Entry hit, taken: counter increments, saturating at all-ones; target overwritten with upd_target.
  - Entry hit, not taken: counter decrements, saturating at 0; target kept.
  - Miss, taken: allocate. Set valid=1, write tag and target, counter = weakly-taken 2^(CTR_BITS-1). Any different-tag occupant is evicted.
  - Miss, not taken: no change.
- Flush (en && flush at a rising edge):
  - All valid bits clear next cycle.
  - Flush wins over a simultaneous update; that update is dropped.
- Same-index lookup and update in one cycle: the lookup returns pre-update contents. There is no write bypass.
- en low: table and stats hold; the lookup stays live.
- CTR_BITS=1: the counter is a last-outcome bit. Weakly-not-taken is 0 and weakly-taken is 1.

Optional Feature:
- Macro BHT_STATS_EN.
- Defined:
  - stat_updates increments on en && upd_en.
  - stat_mispredicts increments on en && upd_en && upd_mispredict.
  - Both saturate at 16'hFFFF, are not affected by flush, and clear on reset.
- Undefined: both outputs are constant 0, no counter flops exist, and upd_mispredict is unused.

Decomposition:
- Shared header (Core.vh style) holds:
  - counter init macros, weakly-taken and weakly-not-taken as functions of CTR_BITS;
  - tag/index width localparams;
  - the stats width, 16.
- One combinational sub-module, cmb_sat_counter_next: inputs ctr and taken, output next ctr, parametrised by CTR_BITS.
- Table storage stays inline as flop arrays.

Test Plan (defaults IM_ADDR_BIT=10, INDEX_BIT=6, CTR_BITS=2):
- Reset, then pc=0x045 -> pred_taken=0, pc_guessed=0x046. pc=0x3FF -> pc_guessed=0x000.
- Update upd_pc=0x045, taken, target 0x100. Next cycle pc=0x045 -> pred_taken=1, pc_guessed=0x100 (counter 2). Then pc=0x005 (same index, tag 0) -> pred_taken=0, pc_guessed=0x006.
- Train 0x045 taken 3x, then not-taken 1x -> still predicts taken (counter 3→2). A second not-taken -> pc_guessed=0x046 (counter 1). Further not-takens saturate at 0.
- Update not-taken miss at 0x020 -> no allocation. Lookup 0x020 -> pc_guessed=0x021.
- Allocated 0x045, then flush together with upd_en on 0x045 taken -> next cycle lookup misses and the update is dropped. With en=0, an update is ignored.
- BHT_STATS_EN defined: 5 updates with 2 mispredicts -> stat_updates=5, stat_mispredicts=2. Preload near saturation and confirm the count holds at 0xFFFF. Undefined: both outputs 0 throughout.
